// File: rtl/mc_pkg.sv
// Shared states, ALU operation codes, opcode/funct values and mux-select encodings for the
// multicycle main controller.
package mc_pkg;

   typedef enum logic [4:0] {
      StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec, StAluWb,
      StIExecS, StIExecZ, StIWb, StBranch, StJump, StJal, StJr, StMdStart, StMdWait
   } state_t;

   typedef enum logic [3:0] {
      AluAdd   = 4'd0,
      AluSub   = 4'd1,
      AluAnd   = 4'd2,
      AluOr    = 4'd3,
      AluXor   = 4'd4,
      AluSlt   = 4'd5,
      AluLui   = 4'd6,
      AluLez   = 4'd7,
      AluGtz   = 4'd8,
      AluFunct = 4'd9
   } aluop_t;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpBlez  = 6'b000110;
   localparam logic [5:0] OpBgtz  = 6'b000111;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpXori  = 6'b001110;
   localparam logic [5:0] OpLui   = 6'b001111;
   localparam logic [5:0] OpLb    = 6'b100000;
   localparam logic [5:0] OpLh    = 6'b100001;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpLbu   = 6'b100100;
   localparam logic [5:0] OpSw    = 6'b101011;

   localparam logic [5:0] FnJr       = 6'b001000;
   localparam logic [3:0] FnMulDivHi = 4'b0110;

   localparam logic [1:0] RegDstRt    = 2'd0;
   localparam logic [1:0] RegDstRd    = 2'd1;
   localparam logic [1:0] RegDstRa    = 2'd2;
   localparam logic [1:0] MemToRegAlu = 2'd0;
   localparam logic [1:0] MemToRegMem = 2'd1;
   localparam logic [1:0] MemToRegPc  = 2'd2;
   localparam logic [1:0] SrcBRt      = 2'd0;
   localparam logic [1:0] SrcBFour    = 2'd1;
   localparam logic [1:0] SrcBImm     = 2'd2;
   localparam logic [1:0] SrcBImmSh   = 2'd3;
   localparam logic [1:0] PcSrcAlu    = 2'd0;
   localparam logic [1:0] PcSrcAluOut = 2'd1;
   localparam logic [1:0] PcSrcJump   = 2'd2;
   localparam logic [1:0] PcSrcRs     = 2'd3;

   // Instruction class dispatch out of DECODE; StFetch means unsupported.
   function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] funct);
      state_t ns;
      ns = StFetch;
      case (op)
         OpRtype: begin
            if (funct == FnJr) ns = StJr;
            else if (funct[5:2] == FnMulDivHi) ns = StMdStart;
            else ns = StExec;
         end
         OpLw, OpLh, OpLb, OpLbu, OpSw:    ns = StMemAdr;
         OpBeq, OpBne, OpBlez, OpBgtz:     ns = StBranch;
         OpAddi, OpSlti:                   ns = StIExecS;
         OpAndi, OpOri, OpXori, OpLui:     ns = StIExecZ;
         OpJ:                              ns = StJump;
         OpJal:                            ns = StJal;
         default:                          ns = StFetch;
      endcase
      return ns;
   endfunction

endpackage

// File: rtl/mc_md_counter.sv
// Loadable down-counter pacing the mult/div wait; holds at zero rather than wrapping.
module mc_md_counter #(
   parameter int unsigned Width = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS32 main controller: Moore FSM driving datapath muxes and enables per cycle,
// with memory-ready handshake and a fixed-length mult/div wait.
module mc_maindec
   import mc_pkg::*;
#(
   parameter int unsigned MULDIV_CYCLES = 32,
   parameter bit          MEM_HANDSHAKE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       branch,
   output logic       ne,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic [1:0] regdst,
   output logic [1:0] memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [3:0] aluop,
   output logic       half,
   output logic       b,
   output logic       lbu,
   output logic       mdstart,
   output logic       illegal
);

   localparam int unsigned CntW = $clog2(MULDIV_CYCLES + 1);

   state_t state_q, state_d;
   logic   mem_ok, cnt_load, cnt_dec, cnt_zero;
   logic   size_half, size_b, size_lbu;

   assign mem_ok    = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign size_half = (op == OpLh);
   assign size_b    = (op == OpLb) || (op == OpLbu);
   assign size_lbu  = (op == OpLbu);

   mc_md_counter #(
      .Width(CntW)
   ) u_md_counter (
      .clk_i      (clk),
      .rst_i      (reset),
      .load_i     (cnt_load),
      .load_val_i (CntW'(MULDIV_CYCLES - 1)),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      ne       = 1'b0;
      iord     = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = RegDstRt;
      memtoreg = MemToRegAlu;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = SrcBRt;
      pcsrc    = PcSrcAlu;
      aluop    = AluAdd;
      half     = 1'b0;
      b        = 1'b0;
      lbu      = 1'b0;
      mdstart  = 1'b0;
      illegal  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;

      case (state_q)
         StFetch: begin
            memread = 1'b1;
            alusrcb = SrcBFour;
            if (mem_ok) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            alusrcb = SrcBImmSh;
            state_d = decode_next(op, funct);
            illegal = (state_d == StFetch);
         end
         StMemAdr: begin
            alusrca = 1'b1;
            alusrcb = SrcBImm;
            state_d = (op == OpSw) ? StMemWr : StMemRd;
         end
         StMemRd: begin
            memread = 1'b1;
            iord    = 1'b1;
            half    = size_half;
            b       = size_b;
            lbu     = size_lbu;
            if (mem_ok) state_d = StMemWb;
         end
         StMemWb: begin
            memtoreg = MemToRegMem;
            regwrite = 1'b1;
            half     = size_half;
            b        = size_b;
            lbu      = size_lbu;
            state_d  = StFetch;
         end
         StMemWr: begin
            memwrite = 1'b1;
            iord     = 1'b1;
            if (mem_ok) state_d = StFetch;
         end
         StExec: begin
            alusrca = 1'b1;
            aluop   = AluFunct;
            state_d = StAluWb;
         end
         StAluWb: begin
            regdst   = RegDstRd;
            regwrite = 1'b1;
            state_d  = StFetch;
         end
         StIExecS: begin
            alusrca = 1'b1;
            alusrcb = SrcBImm;
            aluop   = (op == OpSlti) ? AluSlt : AluAdd;
            state_d = StIWb;
         end
         StIExecZ: begin
            alusrca = 1'b1;
            alusrcb = SrcBImm;
            case (op)
               OpAndi:  aluop = AluAnd;
               OpOri:   aluop = AluOr;
               OpXori:  aluop = AluXor;
               default: aluop = AluLui;
            endcase
            state_d = StIWb;
         end
         StIWb: begin
            regwrite = 1'b1;
            state_d  = StFetch;
         end
         StBranch: begin
            alusrca = 1'b1;
            pcsrc   = PcSrcAluOut;
            branch  = 1'b1;
            ne      = (op == OpBne);
            case (op)
               OpBlez:  aluop = AluLez;
               OpBgtz:  aluop = AluGtz;
               default: aluop = AluSub;
            endcase
            state_d = StFetch;
         end
         StJump: begin
            pcsrc   = PcSrcJump;
            pcwrite = 1'b1;
            state_d = StFetch;
         end
         StJal: begin
            pcsrc    = PcSrcJump;
            pcwrite  = 1'b1;
            regdst   = RegDstRa;
            memtoreg = MemToRegPc;
            regwrite = 1'b1;
            state_d  = StFetch;
         end
         StJr: begin
            pcsrc   = PcSrcRs;
            pcwrite = 1'b1;
            state_d = StFetch;
         end
         StMdStart: begin
            mdstart  = 1'b1;
            cnt_load = 1'b1;
            state_d  = StMdWait;
         end
         StMdWait: begin
            if (cnt_zero) state_d = StFetch;
            else          cnt_dec = 1'b1;
         end
         default: state_d = StFetch;
      endcase

      // Reset is asynchronous, so enables must drop combinationally too.
      if (reset) begin
         pcwrite  = 1'b0;
         branch   = 1'b0;
         memread  = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
         mdstart  = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboard bench for mc_maindec: per-instruction cycle model feeds expected outputs to a
// negedge monitor.
module tb_mc_maindec;
   import mc_pkg::*;

   localparam int unsigned MD = 4;

   typedef struct packed {
      logic       pcwrite, branch, ne, iord, memread, memwrite, irwrite;
      logic [1:0] regdst, memtoreg;
      logic       regwrite, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic [3:0] aluop;
      logic       half, b, lbu, mdstart, illegal;
   } out_t;

   typedef struct {
      string      name;
      logic       rst;
      logic       mr;
      logic [5:0] op;
      logic [5:0] funct;
      out_t       exp;
   } stim_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = '0, funct = '0;
   logic       mem_ready = 1'b0;
   logic       pcwrite, branch, ne, iord, memread, memwrite, irwrite, regwrite, alusrca;
   logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
   logic [3:0] aluop;
   logic       half, b, lbu, mdstart, illegal;

   stim_t stim_q[$];
   stim_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   mc_maindec #(
      .MULDIV_CYCLES(MD),
      .MEM_HANDSHAKE(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .branch(branch), .ne(ne), .iord(iord), .memread(memread),
      .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .aluop(aluop), .half(half), .b(b), .lbu(lbu), .mdstart(mdstart), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic out_t base_v();
      out_t o;
      o = '0;
      o.aluop = AluAdd;
      return o;
   endfunction

   function automatic out_t fetch_v();
      out_t o;
      o = base_v();
      o.memread = 1'b1;
      o.alusrcb = 2'd1;
      return o;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic string kind_of(input logic [5:0] o, input logic [5:0] f);
      string k;
      if (o == 6'h00) begin
         if (f == 6'h08) k = "jr";
         else if (f >= 6'h18 && f <= 6'h1b) k = "md";
         else k = "rtype";
      end else begin
         case (o)
            6'h20, 6'h21, 6'h23, 6'h24:               k = "load";
            6'h2b:                                    k = "store";
            6'h04, 6'h05, 6'h06, 6'h07:               k = "branch";
            6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f: k = "imm";
            6'h02:                                    k = "j";
            6'h03:                                    k = "jal";
            default:                                  k = "illegal";
         endcase
      end
      return k;
   endfunction

   function automatic void add(input string n, input logic rst, input logic mr,
                               input logic [5:0] o, input logic [5:0] f, input out_t e);
      stim_t s;
      s.name = n; s.rst = rst; s.mr = mr; s.op = o; s.funct = f; s.exp = e;
      stim_q.push_back(s);
   endfunction

   // Builds the expected cycle sequence of one instruction; abort>0 cuts it after that many
   // cycles and asserts reset for two cycles.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw,
                            input int mw, input int abort);
      out_t  e;
      string k;
      int    start;
      k = kind_of(o, f);
      start = stim_q.size();
      for (int i = 0; i < fw; i++) add({k, ".FETCH-wait"}, 1'b0, 1'b0, o, f, fetch_v());
      e = fetch_v(); e.irwrite = 1'b1; e.pcwrite = 1'b1;
      add({k, ".FETCH"}, 1'b0, 1'b1, o, f, e);
      e = base_v(); e.alusrcb = 2'd3; e.illegal = (k == "illegal");
      add({k, ".DECODE"}, 1'b0, rnd_bit(), o, f, e);
      if (k == "load" || k == "store") begin
         e = base_v(); e.alusrca = 1'b1; e.alusrcb = 2'd2;
         add({k, ".MEMADR"}, 1'b0, rnd_bit(), o, f, e);
      end
      if (k == "load") begin
         e = base_v(); e.memread = 1'b1; e.iord = 1'b1;
         e.half = (o == 6'h21); e.b = (o == 6'h20 || o == 6'h24); e.lbu = (o == 6'h24);
         for (int i = 0; i <= mw; i++) add({k, ".MEMRD"}, 1'b0, (i == mw), o, f, e);
         e.memread = 1'b0; e.iord = 1'b0; e.memtoreg = 2'd1; e.regwrite = 1'b1;
         add({k, ".MEMWB"}, 1'b0, rnd_bit(), o, f, e);
      end else if (k == "store") begin
         e = base_v(); e.memwrite = 1'b1; e.iord = 1'b1;
         for (int i = 0; i <= mw; i++) add({k, ".MEMWR"}, 1'b0, (i == mw), o, f, e);
      end else if (k == "rtype") begin
         e = base_v(); e.alusrca = 1'b1; e.aluop = AluFunct;
         add({k, ".EXEC"}, 1'b0, rnd_bit(), o, f, e);
         e = base_v(); e.regdst = 2'd1; e.regwrite = 1'b1;
         add({k, ".ALUWB"}, 1'b0, rnd_bit(), o, f, e);
      end else if (k == "imm") begin
         e = base_v(); e.alusrca = 1'b1; e.alusrcb = 2'd2;
         case (o)
            6'h0a:   e.aluop = AluSlt;
            6'h0c:   e.aluop = AluAnd;
            6'h0d:   e.aluop = AluOr;
            6'h0e:   e.aluop = AluXor;
            6'h0f:   e.aluop = AluLui;
            default: e.aluop = AluAdd;
         endcase
         add({k, ".IEXEC"}, 1'b0, rnd_bit(), o, f, e);
         e = base_v(); e.regwrite = 1'b1;
         add({k, ".IWB"}, 1'b0, rnd_bit(), o, f, e);
      end else if (k == "branch") begin
         e = base_v(); e.alusrca = 1'b1; e.pcsrc = 2'd1; e.branch = 1'b1;
         e.ne = (o == 6'h05);
         e.aluop = (o == 6'h06) ? AluLez : (o == 6'h07) ? AluGtz : AluSub;
         add({k, ".BRANCH"}, 1'b0, rnd_bit(), o, f, e);
      end else if (k == "j" || k == "jal" || k == "jr") begin
         e = base_v(); e.pcwrite = 1'b1; e.pcsrc = (k == "jr") ? 2'd3 : 2'd2;
         if (k == "jal") begin
            e.regdst = 2'd2; e.memtoreg = 2'd2; e.regwrite = 1'b1;
         end
         add({k, ".JUMP"}, 1'b0, rnd_bit(), o, f, e);
      end else if (k == "md") begin
         e = base_v(); e.mdstart = 1'b1;
         add({k, ".MDSTART"}, 1'b0, rnd_bit(), o, f, e);
         for (int i = 0; i < MD; i++) add({k, ".MDWAIT"}, 1'b0, rnd_bit(), o, f, base_v());
      end
      if (abort > 0) begin
         while (stim_q.size() > start + abort) void'(stim_q.pop_back());
         e = fetch_v(); e.memread = 1'b0;
         repeat (2) add({k, ".RESET"}, 1'b1, rnd_bit(), o, f, e);
      end
   endtask

   // Monitor: compares one expected vector per cycle, away from the rising edge.
   initial begin
      stim_t s;
      out_t  act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            act = {pcwrite, branch, ne, iord, memread, memwrite, irwrite, regdst, memtoreg,
                   regwrite, alusrca, alusrcb, pcsrc, aluop, half, b, lbu, mdstart, illegal};
            checks++;
            if (act !== s.exp) begin
               errors++;
               $display("FAIL %s @%0t: got %b want %b", s.name, $time, act, s.exp);
            end
         end
      end
   end

   initial begin
      stim_t       s;
      out_t        e;
      logic [5:0]  o, f;
      logic [5:0]  ops [18] = '{6'h23, 6'h21, 6'h20, 6'h24, 6'h2b, 6'h04, 6'h05, 6'h06, 6'h07,
                                6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h02, 6'h03, 6'h00};
      logic [5:0]  fns [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08, 6'h18, 6'h19, 6'h1a,
                                6'h1b};
      int          r;

      e = fetch_v(); e.memread = 1'b0;
      repeat (3) add("reset", 1'b1, 1'b1, 6'h00, 6'h20, e);
      run_instr(6'h00, 6'h20, 0, 0, 0);          // add
      run_instr(6'h23, 6'h00, 0, 3, 0);          // lw, memory slow
      run_instr(6'h00, 6'h18, 0, 0, 0);          // mult
      run_instr(6'h05, 6'h00, 1, 0, 0);          // bne
      run_instr(6'h03, 6'h00, 0, 0, 0);          // jal
      run_instr(6'h3f, 6'h00, 0, 0, 0);          // unsupported op
      run_instr(6'h2b, 6'h00, 0, 5, 5);          // sw aborted by reset in MEMWR
      run_instr(6'h00, 6'h20, 0, 0, 0);
      run_instr(6'h00, 6'h1a, 1, 0, 5);          // div aborted by reset in MDWAIT
      run_instr(6'h00, 6'h19, 0, 0, 0);
      run_instr(6'h2b, 6'h00, 2, 2, 0);
      run_instr(6'h24, 6'h00, 0, 1, 0);

      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         f = 6'($urandom_range(0, 63));
         if (r == 0) begin
            o = 6'($urandom_range(0, 63));
         end else if (r < 4) begin
            o = 6'h00;
            if (rnd_bit()) f = fns[$urandom_range(0, 9)];
         end else begin
            o = ops[$urandom_range(0, 17)];
         end
         run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0);
      end

      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         @(posedge clk);
         #1;
         reset     = s.rst;
         mem_ready = s.mr;
         op        = s.op;
         funct     = s.funct;
         exp_q.push_back(s);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
